mcu_control_fsm: RTL and testbench

//  Main control unit sequencing each instruction of the RV32I core: fetch, IR latch, decode, data-memory wait, complete.

---
 rtl/mcu_control_fsm.sv | 170 +++++++++++++++++
 tb/tb_mcu_control_fsm.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_control_fsm.sv
// mcu_control_fsm: main sequencer of the RV32I core.
// Each instruction goes through FETCH -> LATCH -> DECODE, and a load or store also goes
// through WAIT_LOAD/WAIT_STORE and COMPLETE. The unit issues the fetch request, the IR
// load, the PC update and the load write-back strobes, and it counts retired instructions.
// Optional feature: define MCU_WATCHDOG_EN to trap when a memory ready input does not
// arrive within TIMEOUT_CYCLES cycles.
// Memory handshake: MCU_Imem_Req is held high for the whole of FETCH. The fetch completes
// on the first rising edge at which MCU_Imem_Ready is high. WAIT_LOAD and WAIT_STORE end
// in the same way on MCU_Dmem_Ready. A ready input that is high in any other state is ignored.
module mcu_control_fsm #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             MCU_Clock,
  input  logic             MCU_Reset_n,
  input  logic [6:0]       MCU_Opcode_InBUS,
  input  logic             MCU_Imem_Ready,
  input  logic             MCU_Dmem_Ready,
  output logic [2:0]       MCU_State_OutBUS,
  output logic             MCU_Imem_Req,
  output logic             MCU_Ir_Load,
  output logic             MCU_Pc_Update,
  output logic             MCU_Load_Wb,
  output logic             MCU_Illegal_Op,
  output logic             MCU_Timeout_Err,
  output logic [CNT_W-1:0] MCU_Retired_Count
);

  // The decode unit reads this encoding directly, so the values must not change.
  typedef enum logic [2:0] {
    S_RESET      = 3'b000,
    S_FETCH      = 3'b001,
    S_LATCH      = 3'b010,
    S_DECODE     = 3'b011,
    S_WAIT_LOAD  = 3'b100,
    S_WAIT_STORE = 3'b101,
    S_COMPLETE   = 3'b110,
    S_TRAP       = 3'b111
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  state_t           state_q, state_d;
  logic             is_load_q, is_load_d;   // remembers whether COMPLETE follows a load
  logic             illegal_q;
  logic             illegal_set;
  logic             pc_update;
  logic             wd_expired;
  logic [CNT_W-1:0] retired_q;

`ifdef MCU_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            in_wait;
  logic            ready_now;
  logic            timeout_q;

  assign in_wait   = state_q inside {S_FETCH, S_WAIT_LOAD, S_WAIT_STORE};
  assign ready_now = (state_q == S_FETCH) ? MCU_Imem_Ready : MCU_Dmem_Ready;
  // When ready arrives on the limit cycle, the normal transition takes priority over the trap.
  assign wd_expired = in_wait && !ready_now && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Count idle cycles in a wait state. Any other state, or a ready, clears the count, so each entry starts from zero.
  always_ff @(posedge MCU_Clock or negedge MCU_Reset_n) begin
    if (!MCU_Reset_n) begin
      wd_cnt_q <= '0;
    end else if (in_wait && !ready_now && !wd_expired) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end else begin
      wd_cnt_q <= '0;
    end
  end

  // The timeout flag stays set until the next reset.
  always_ff @(posedge MCU_Clock or negedge MCU_Reset_n) begin
    if (!MCU_Reset_n) begin
      timeout_q <= 1'b0;
    end else if (wd_expired) begin
      timeout_q <= 1'b1;
    end
  end

  assign MCU_Timeout_Err = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wd_expired         = 1'b0;
  assign MCU_Timeout_Err    = 1'b0;
`endif

  // State register, load marker, sticky illegal flag and retired counter (the counter wraps silently).
  always_ff @(posedge MCU_Clock or negedge MCU_Reset_n) begin
    if (!MCU_Reset_n) begin
      state_q   <= S_RESET;
      is_load_q <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      if (illegal_set) illegal_q <= 1'b1;
      if (pc_update)   retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next-state logic, plus the Mealy PC update (DECODE) and the Moore PC update (COMPLETE).
  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    pc_update   = 1'b0;
    illegal_set = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (MCU_Imem_Ready)  state_d = S_LATCH;
        else if (wd_expired) state_d = S_TRAP;
      end
      S_LATCH: state_d = S_DECODE;
      S_DECODE: begin
        case (MCU_Opcode_InBUS)
          OP_LOAD: begin
            state_d   = S_WAIT_LOAD;
            is_load_d = 1'b1;
          end
          OP_STORE: begin
            state_d   = S_WAIT_STORE;
            is_load_d = 1'b0;
          end
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_IMM, OP_REG: begin
            state_d   = S_FETCH;
            pc_update = 1'b1;
          end
          default: begin
            state_d     = S_TRAP;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_WAIT_LOAD, S_WAIT_STORE: begin
        if (MCU_Dmem_Ready)  state_d = S_COMPLETE;
        else if (wd_expired) state_d = S_TRAP;
      end
      S_COMPLETE: begin
        pc_update = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_RESET;
    endcase
  end

  assign MCU_State_OutBUS  = state_q;
  assign MCU_Imem_Req      = (state_q == S_FETCH);
  assign MCU_Ir_Load       = (state_q == S_LATCH);
  assign MCU_Pc_Update     = pc_update;
  assign MCU_Load_Wb       = (state_q == S_COMPLETE) && is_load_q;
  assign MCU_Illegal_Op    = illegal_q;
  assign MCU_Retired_Count = retired_q;

endmodule

// File: tb/tb_mcu_control_fsm.sv
// tb_mcu_control_fsm: bench for mcu_control_fsm.
// Each instruction is expanded into the cycle trace that the sequencing rules predict.
// The trace is held as one input queue and one expected-output queue, and the DUT is
// checked against the expected queue on every cycle.
module tb_mcu_control_fsm;
  localparam int CNT_W          = 6;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int W              = 9 + CNT_W;

  localparam logic [2:0] ST_RESET = 3'd0, ST_FETCH = 3'd1, ST_LATCH = 3'd2, ST_DECODE = 3'd3;
  localparam logic [2:0] ST_WLOAD = 3'd4, ST_WSTORE = 3'd5, ST_COMPLETE = 3'd6, ST_TRAP = 3'd7;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011, OP_REG = 7'b0110011, OP_JAL = 7'b1101111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic imem_ready = 1'b0;
  logic dmem_ready = 1'b0;

  logic [2:0]       state_bus;
  logic             imem_req, ir_load, pc_update, load_wb, illegal_op, timeout_err;
  logic [CNT_W-1:0] retired;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  logic [8:0]   stim_q[$];
  logic         m_illegal;
  logic         m_timeout;
  int           m_cnt;
  logic [6:0]   legal_ops[9] = '{7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                 7'b1100111, 7'b1100011, 7'b0010011, 7'b0110011};

  mcu_control_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) dut (
    .MCU_Clock(clk),
    .MCU_Reset_n(rst_n),
    .MCU_Opcode_InBUS(opcode),
    .MCU_Imem_Ready(imem_ready),
    .MCU_Dmem_Ready(dmem_ready),
    .MCU_State_OutBUS(state_bus),
    .MCU_Imem_Req(imem_req),
    .MCU_Ir_Load(ir_load),
    .MCU_Pc_Update(pc_update),
    .MCU_Load_Wb(load_wb),
    .MCU_Illegal_Op(illegal_op),
    .MCU_Timeout_Err(timeout_err),
    .MCU_Retired_Count(retired)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish, got time %0t, required completion", $time);
    $fatal(1);
  end

  // Opcodes that retire directly from DECODE
  function automatic logic retires_in_decode(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] op;
    do op = 7'($urandom); while (retires_in_decode(op) || op == OP_LOAD || op == OP_STORE);
    return op;
  endfunction

  // Value for an input that the DUT ignores in the current cycle: random when noisy, otherwise held high
  function automatic logic nz(input logic noise);
    return noise ? 1'($urandom) : 1'b1;
  endfunction

  function automatic logic [6:0] nop(input logic noise, input logic [6:0] op);
    return noise ? 7'($urandom) : op;
  endfunction

  // Append one cycle to the trace: the inputs to drive and the outputs expected in that cycle
  task automatic push_cycle(input logic ir, input logic dr, input logic [6:0] op, input logic [2:0] st,
                            input logic req, input logic ld, input logic pc, input logic wb);
    stim_q.push_back({ir, dr, op});
    exp_q.push_back({st, req, ld, pc, wb, m_illegal, m_timeout, CNT_W'(m_cnt)});
    if (pc) m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  // Expand one instruction into its cycles: d_i fetch stalls and d_d data-memory stalls
  task automatic plan_instr(input logic [6:0] op, input int d_i, input int d_d, input logic noise);
    logic       is_ld;
    logic [2:0] wst;
    for (int k = 0; k < d_i; k++) push_cycle(1'b0, nz(noise), nop(noise, op), ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    push_cycle(1'b1, nz(noise), nop(noise, op), ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    push_cycle(nz(noise), nz(noise), nop(noise, op), ST_LATCH, 1'b0, 1'b1, 1'b0, 1'b0);
    if (op == OP_LOAD || op == OP_STORE) begin
      is_ld = (op == OP_LOAD);
      wst   = is_ld ? ST_WLOAD : ST_WSTORE;
      push_cycle(nz(noise), nz(noise), op, ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < d_d; k++) push_cycle(nz(noise), 1'b0, nop(noise, op), wst, 1'b0, 1'b0, 1'b0, 1'b0);
      push_cycle(nz(noise), 1'b1, nop(noise, op), wst, 1'b0, 1'b0, 1'b0, 1'b0);
      push_cycle(nz(noise), nz(noise), nop(noise, op), ST_COMPLETE, 1'b0, 1'b0, 1'b1, is_ld);
    end else if (retires_in_decode(op)) begin
      push_cycle(nz(noise), nz(noise), op, ST_DECODE, 1'b0, 1'b0, 1'b1, 1'b0);
    end else begin
      push_cycle(nz(noise), nz(noise), op, ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
      m_illegal = 1'b1;
    end
  endtask

  // Driver and scoreboard: apply each planned cycle at negedge and compare 1 ns later
  task automatic drain(input string name);
    logic [W-1:0] exp_v, act_v;
    logic [8:0]   s;
    int           cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      s     = stim_q.pop_front();
      exp_v = exp_q.pop_front();
      @(negedge clk);
      {imem_ready, dmem_ready, opcode} = s;
      #1;
      act_v = {state_bus, imem_req, ir_load, pc_update, load_wb, illegal_op, timeout_err, retired};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL %s cycle %0d: got state=%b req/ir/pc/wb/ill/to=%b cnt=%0d, expected state=%b req/ir/pc/wb/ill/to=%b cnt=%0d",
                 name, cyc, act_v[W-1 -: 3], act_v[W-4 -: 6], act_v[CNT_W-1:0],
                 exp_v[W-1 -: 3], exp_v[W-4 -: 6], exp_v[CNT_W-1:0]);
      end
      cyc++;
    end
  endtask

  // Reset: every output must be zero while reset is held and during the first cycle after release
  task automatic test_reset();
    logic [W-1:0] act_v;
    @(negedge clk);
    rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = OP_IMM;
    #1;
    act_v = {state_bus, imem_req, ir_load, pc_update, load_wb, illegal_op, timeout_err, retired};
    tests++;
    if (act_v !== '0) begin
      fails++;
      $display("FAIL reset_held: got outputs %b, expected all zero", act_v);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    act_v = {state_bus, imem_req, ir_load, pc_update, load_wb, illegal_op, timeout_err, retired};
    tests++;
    if (act_v !== '0) begin
      fails++;
      $display("FAIL reset_release_cycle: got outputs %b, expected all zero", act_v);
    end
    m_cnt = 0; m_illegal = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic test_alu_basic();
    test_reset();
    plan_instr(OP_IMM, 0, 0, 1'b0);
    push_cycle(1'b0, 1'b0, OP_IMM, ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("alu_basic");
    tests++;
    if (retired !== CNT_W'(1)) begin
      fails++;
      $display("FAIL alu_count: got %0d, expected 1", retired);
    end
  endtask

  task automatic test_load();
    plan_instr(OP_LOAD, 0, 4, 1'b0);
    push_cycle(1'b0, 1'b1, OP_LOAD, ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("load_wait4");
  endtask

  // Imem_Ready stays high through DECODE and the wait state and must be ignored there
  task automatic test_store();
    plan_instr(OP_STORE, 2, 1, 1'b0);
    plan_instr(OP_STORE, 0, 0, 1'b0);
    push_cycle(1'b0, 1'b1, OP_STORE, ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("store");
  endtask

  task automatic test_illegal();
    plan_instr(7'b1111111, 0, 0, 1'b0);
    for (int k = 0; k < 5; k++) push_cycle(1'b1, 1'b1, OP_IMM, ST_TRAP, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("illegal_trap");
    test_reset();
  endtask

  // An asynchronous reset in the middle of WAIT_LOAD must clear the state and the counter without waiting for a clock edge
  task automatic test_reset_mid_load();
    plan_instr(OP_JAL, 0, 0, 1'b1);
    push_cycle(1'b1, 1'b0, OP_LOAD, ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    push_cycle(1'b0, 1'b0, OP_LOAD, ST_LATCH, 1'b0, 1'b1, 1'b0, 1'b0);
    push_cycle(1'b0, 1'b0, OP_LOAD, ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) push_cycle(1'b0, 1'b0, OP_LOAD, ST_WLOAD, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("pre_async_reset");
    #2;
    rst_n = 1'b0; dmem_ready = 1'b1;
    #1;
    tests++;
    if ({state_bus, pc_update, load_wb, retired} !== '0) begin
      fails++;
      $display("FAIL async_reset_mid_load: got state=%b pc=%b wb=%b cnt=%0d, expected state=000 pc=0 wb=0 cnt=0",
               state_bus, pc_update, load_wb, retired);
    end
    test_reset();
  endtask

  // Retire exactly 2^CNT_W instructions from reset, so the counter wraps back to zero
  task automatic test_wrap();
    test_reset();
    for (int n = 0; n < (1 << CNT_W); n++)
      plan_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    push_cycle(1'b0, 1'b1, OP_IMM, ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("wrap");
    tests++;
    if (retired !== '0) begin
      fails++;
      $display("FAIL count_wrap: got %0d, expected 0", retired);
    end
  endtask

  // Random opcodes, stall lengths and ignored-input noise, ending with an illegal opcode
  task automatic test_random();
    test_reset();
    for (int n = 0; n < 120; n++) begin
      plan_instr(legal_ops[$urandom_range(0, 8)],
                 ($urandom_range(0, 9) == 0) ? TIMEOUT_CYCLES - 1 : $urandom_range(0, 4),
                 ($urandom_range(0, 9) == 0) ? TIMEOUT_CYCLES - 1 : $urandom_range(0, 4), 1'b1);
    end
    plan_instr(rand_illegal(), $urandom_range(0, 3), 0, 1'b1);
    for (int k = 0; k < 3; k++) push_cycle(nz(1'b1), nz(1'b1), nop(1'b1, OP_IMM), ST_TRAP, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("random");
  endtask

  task automatic test_watchdog();
`ifdef MCU_WATCHDOG_EN
    test_reset();
    for (int k = 0; k < TIMEOUT_CYCLES; k++) push_cycle(1'b0, 1'b1, OP_IMM, ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    m_timeout = 1'b1;
    for (int k = 0; k < 4; k++) push_cycle(1'b1, 1'b1, OP_IMM, ST_TRAP, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("fetch_timeout");
    test_reset();
    plan_instr(OP_IMM, TIMEOUT_CYCLES - 1, 0, 1'b0);
    push_cycle(1'b1, 1'b0, OP_STORE, ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    push_cycle(1'b0, 1'b0, OP_STORE, ST_LATCH, 1'b0, 1'b1, 1'b0, 1'b0);
    push_cycle(1'b0, 1'b0, OP_STORE, ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < TIMEOUT_CYCLES; k++) push_cycle(1'b1, 1'b0, OP_STORE, ST_WSTORE, 1'b0, 1'b0, 1'b0, 1'b0);
    m_timeout = 1'b1;
    for (int k = 0; k < 3; k++) push_cycle(1'b1, 1'b1, OP_IMM, ST_TRAP, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("store_timeout");
`else
    test_reset();
    plan_instr(OP_REG, 300, 0, 1'b1);
    push_cycle(1'b0, 1'b0, OP_REG, ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("no_watchdog_long_fetch");
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL no_watchdog_timeout_flag: got %b, expected 0", timeout_err);
    end
`endif
  endtask

  // Test sequence
  initial begin
    m_cnt = 0; m_illegal = 1'b0; m_timeout = 1'b0;
    test_reset();
    test_alu_basic();
    test_load();
    test_store();
    test_illegal();
    test_reset_mid_load();
    test_wrap();
    test_random();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
